// File: rtl/t03_pc_ctrl.sv
// Program counter with trap/mret redirection, alignment checking, saved EPC
// and a circular return-address stack for call/return prediction.
module t03_pc_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] BASE_ADDRESS = '0,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze_pc,
  input  logic [1:0]      control,
  input  logic [XLEN-1:0] offset,
  input  logic [XLEN-1:0] alu_result,
  input  logic            is_call,
  input  logic            is_return,
  input  logic            trap_req,
  input  logic            mret,
  output logic [XLEN-1:0] current_pc,
  output logic [XLEN-1:0] to_memory,
  output logic [XLEN-1:0] epc,
  output logic            in_handler,
  output logic            misaligned,
  output logic            fault,
  output logic            ras_valid,
  output logic [XLEN-1:0] ras_top
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN = 1'b0, HANDLER = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d, epc_q, epc_d;
  logic              fault_q, fault_d;
  logic [XLEN-1:0]   ras_q [RAS_DEPTH];
  logic [XLEN-1:0]   ras_d [RAS_DEPTH];
  logic [PW-1:0]     ptr_q, ptr_d, ptr_m1;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   seq, tgt, next_pc;
  logic              mis, hnd, redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      fault_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      fault_q <= fault_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ras_q   <= ras_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!freeze_pc) begin
      case (state_q)
        RUN:     if (trap_req || mis) state_d = HANDLER;
        HANDLER: if (mret && !trap_req) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    hnd = (state_q == HANDLER);
    seq = pc_q + XLEN'(4);
    case (control)
      2'b00:   tgt = seq;
      2'b10:   tgt = pc_q + offset;
      default: tgt = alu_result;
    endcase
    mis      = |tgt[1:0];
    redirect = trap_req || mis;
    // Inside the handler a misaligned target is not re-trapped; it is forced aligned.
    if (trap_req || (mis && !hnd)) next_pc = TRAP_VECTOR;
    else if (hnd && mret)          next_pc = epc_q;
    else if (mis)                  next_pc = {tgt[XLEN-1:2], 2'b00};
    else                           next_pc = tgt;
    pc_d    = freeze_pc ? pc_q : next_pc;
    epc_d   = (!freeze_pc && !hnd && redirect) ? pc_q : epc_q;
    fault_d = fault_q | (!freeze_pc && hnd && redirect);
  end

  always_comb begin
    ras_d  = ras_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    ptr_m1 = ptr_q - PW'(1);
    if (!freeze_pc && !redirect) begin
      if (is_call && is_return && cnt_q != '0) begin
        ras_d[ptr_m1] = seq;
      end else if (is_call) begin
        ras_d[ptr_q] = seq;
        ptr_d = ptr_q + PW'(1);
        if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
      end else if (is_return && cnt_q != '0) begin
        ptr_d = ptr_m1;
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_comb begin
    current_pc = pc_q;
    to_memory  = pc_d + BASE_ADDRESS;
    epc        = epc_q;
    in_handler = hnd;
    misaligned = mis;
    fault      = fault_q;
    ras_valid  = (cnt_q != '0);
    ras_top    = ras_valid ? ras_q[ptr_m1] : '0;
  end
endmodule
